// File: rtl/spindash_pkg.sv
// Shared types and sizing helpers for the ym_mixer audio mixer.
// Holds the mixer state enum, the unity-gain constant and the accumulator width.
package spindash_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      ACCUM,
      DONE
   } mix_state_t;

   // Gain value that leaves a sample unchanged after the final shift.
   function automatic int unity_gain(input int gain_width);
      return 1 << (gain_width - 1);
   endfunction

   // Full product width plus guard bits so summing every channel never wraps.
   function automatic int acc_width(input int in_width,
                                    input int gain_width,
                                    input int ch_count);
      return in_width + gain_width + 1 + $clog2(ch_count);
   endfunction

endpackage

// File: rtl/mix_saturate.sv
// Scales an accumulator down by the unity-gain shift and clamps it to the output range.
// Ports: acc (signed accumulator in), sat (clamped signed result), clip (clamp engaged).
module mix_saturate #(
   parameter int ACC_WIDTH = 28,
   parameter int SHIFT     = 7,
   parameter int OUT_WIDTH = 20
) (
   input  logic [ACC_WIDTH-1:0] acc,
   output logic [OUT_WIDTH-1:0] sat,
   output logic                 clip
);

   logic signed [ACC_WIDTH-1:0] shifted;

   // Arithmetic shift gives floor division by the unity gain.
   assign shifted = $signed(acc) >>> SHIFT;

   generate
      if (ACC_WIDTH > OUT_WIDTH) begin : g_sat
         logic [ACC_WIDTH-OUT_WIDTH:0] top;

         // Value fits only when every bit above the output sign bit matches it.
         assign top = shifted[ACC_WIDTH-1:OUT_WIDTH-1];

         always_comb begin
            clip = 1'b0;
            sat  = shifted[OUT_WIDTH-1:0];
            if (top != '0 && top != '1) begin
               clip = 1'b1;
               if (shifted[ACC_WIDTH-1])
                  sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
               else
                  sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
         end
      end else begin : g_wide
         assign sat  = OUT_WIDTH'(shifted);
         assign clip = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/ym_mixer.sv
// Multi-channel stereo mixer: on each sample_in rising edge, snapshots all voices and
// gains, sums sample*gain one channel per cycle, then scales and saturates the result.
// Ports: clk, rst (sync, active-high); snd_left_in/snd_right_in packed voices;
// sample_in mix trigger; cfg_wr/cfg_ch/cfg_side/cfg_data gain writes; clip_clr;
// mix_left/mix_right/mix_valid results; busy; clip_left/clip_right/overrun sticky flags.
module ym_mixer
   import spindash_pkg::*;
#(
   parameter int CH_COUNT   = 9,
   parameter int IN_WIDTH   = 16,
   parameter int GAIN_WIDTH = 8,
   parameter int OUT_WIDTH  = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [CH_COUNT*IN_WIDTH-1:0] snd_left_in,
   input  logic [CH_COUNT*IN_WIDTH-1:0] snd_right_in,
   input  logic                         sample_in,
   input  logic                         cfg_wr,
   input  logic [4:0]                   cfg_ch,
   input  logic                         cfg_side,
   input  logic [GAIN_WIDTH-1:0]        cfg_data,
   input  logic                         clip_clr,
   output logic [OUT_WIDTH-1:0]         mix_left,
   output logic [OUT_WIDTH-1:0]         mix_right,
   output logic                         mix_valid,
   output logic                         busy,
   output logic                         clip_left,
   output logic                         clip_right,
   output logic                         overrun
);

   localparam int PW = IN_WIDTH + GAIN_WIDTH + 1;
   localparam int AW = acc_width(IN_WIDTH, GAIN_WIDTH, CH_COUNT);
   localparam logic [GAIN_WIDTH-1:0] UNITY =
      GAIN_WIDTH'(unity_gain(GAIN_WIDTH));
   localparam logic [4:0] LAST   = 5'(CH_COUNT - 1);
   localparam logic [5:0] CH_LIM = 6'(CH_COUNT);

   mix_state_t state;
   mix_state_t state_nx;

   logic sample_q;
   logic edge_det;

   logic [CH_COUNT*GAIN_WIDTH-1:0] gain_l;
   logic [CH_COUNT*GAIN_WIDTH-1:0] gain_r;
   logic [CH_COUNT*GAIN_WIDTH-1:0] snap_gl;
   logic [CH_COUNT*GAIN_WIDTH-1:0] snap_gr;
   logic [CH_COUNT*IN_WIDTH-1:0]   snap_l;
   logic [CH_COUNT*IN_WIDTH-1:0]   snap_r;

   logic [4:0]                  idx;
   logic signed [AW-1:0]        acc_l;
   logic signed [AW-1:0]        acc_r;
   logic signed [IN_WIDTH-1:0]  smp_l;
   logic signed [IN_WIDTH-1:0]  smp_r;
   logic [GAIN_WIDTH-1:0]       g_l;
   logic [GAIN_WIDTH-1:0]       g_r;
   logic signed [PW-1:0]        prod_l;
   logic signed [PW-1:0]        prod_r;
   logic [OUT_WIDTH-1:0]        sat_l;
   logic [OUT_WIDTH-1:0]        sat_r;
   logic                        clip_l;
   logic                        clip_r;
   logic                        cfg_ok;

   assign edge_det = sample_in & ~sample_q;
   assign busy     = (state != IDLE);
   assign cfg_ok   = cfg_wr && ({1'b0, cfg_ch} < CH_LIM);

   // Current channel operands, taken from the snapshot so live inputs cannot
   // disturb a mix in progress.
   assign smp_l = $signed(snap_l[int'(idx)*IN_WIDTH +: IN_WIDTH]);
   assign smp_r = $signed(snap_r[int'(idx)*IN_WIDTH +: IN_WIDTH]);
   assign g_l   = snap_gl[int'(idx)*GAIN_WIDTH +: GAIN_WIDTH];
   assign g_r   = snap_gr[int'(idx)*GAIN_WIDTH +: GAIN_WIDTH];

   // Gain is unsigned: zero-extend before the signed multiply.
   assign prod_l = PW'(smp_l) * PW'($signed({1'b0, g_l}));
   assign prod_r = PW'(smp_r) * PW'($signed({1'b0, g_r}));

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (edge_det) state_nx = CAPTURE;
         CAPTURE: state_nx = ACCUM;
         ACCUM:   if (idx == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q   <= 1'b1;
         gain_l     <= {CH_COUNT{UNITY}};
         gain_r     <= {CH_COUNT{UNITY}};
         snap_gl    <= '0;
         snap_gr    <= '0;
         snap_l     <= '0;
         snap_r     <= '0;
         idx        <= '0;
         acc_l      <= '0;
         acc_r      <= '0;
         mix_left   <= '0;
         mix_right  <= '0;
         mix_valid  <= 1'b0;
         clip_left  <= 1'b0;
         clip_right <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         sample_q  <= sample_in;
         mix_valid <= 1'b0;

         if (cfg_ok) begin
            if (cfg_side)
               gain_r[int'(cfg_ch)*GAIN_WIDTH +: GAIN_WIDTH] <= cfg_data;
            else
               gain_l[int'(cfg_ch)*GAIN_WIDTH +: GAIN_WIDTH] <= cfg_data;
         end

         // Snapshot sees the gain registers before any same-edge write.
         if (edge_det && state == IDLE) begin
            snap_l  <= snd_left_in;
            snap_r  <= snd_right_in;
            snap_gl <= gain_l;
            snap_gr <= gain_r;
         end

         if (state == CAPTURE) begin
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
         end

         if (state == ACCUM) begin
            acc_l <= acc_l + AW'(prod_l);
            acc_r <= acc_r + AW'(prod_r);
            idx   <= idx + 5'd1;
         end

         if (state == DONE) begin
            mix_left  <= sat_l;
            mix_right <= sat_r;
            mix_valid <= 1'b1;
         end

         // A new event outranks a same-cycle clear.
         clip_left  <= (state == DONE && clip_l) | (clip_left & ~clip_clr);
         clip_right <= (state == DONE && clip_r) | (clip_right & ~clip_clr);
         overrun    <= (edge_det && state != IDLE) | (overrun & ~clip_clr);
      end
   end

   mix_saturate #(
      .ACC_WIDTH (AW),
      .SHIFT     (GAIN_WIDTH - 1),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_sat_left (
      .acc  (acc_l),
      .sat  (sat_l),
      .clip (clip_l)
   );

   mix_saturate #(
      .ACC_WIDTH (AW),
      .SHIFT     (GAIN_WIDTH - 1),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_sat_right (
      .acc  (acc_r),
      .sat  (sat_r),
      .clip (clip_r)
   );

endmodule
